// File: rtl/f_fetch_unit.sv
// F-stage fetch unit: owns the fetch PC, issues one instruction-memory request at a
// time and holds the returned instruction for the F/D register until it is accepted.
module f_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_npc,
  input  logic              i_stall,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  output logic [ADDR_W-1:0] o_F_pc,
  output logic [31:0]       o_F_instr,
  output logic              o_F_valid,
  output logic              o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              mis_q, mis_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    mis_d      = mis_q;
    o_imem_req = 1'b0;
    o_F_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        o_imem_req = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          instr_d = i_imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        o_F_valid = 1'b1;
        // Low bits of a bad target are dropped; the sticky flag records it.
        if (!i_stall) begin
          pc_d    = {i_npc[ADDR_W-1:2], 2'b00};
          mis_d   = mis_q | (|i_npc[1:0]);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_imem_addr = pc_q;
  assign o_F_pc      = pc_q;
  assign o_F_instr   = instr_q;
  assign o_misalign  = mis_q;

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: a cycle-numbered transaction model predicts
// request cycles, response latency, held instruction/PC and the sticky misalign flag.
module tb_f_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_npc = '0;
  logic        i_stall = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic [31:0] o_F_pc;
  logic [31:0] o_F_instr;
  logic        o_F_valid;
  logic        o_misalign;

  f_fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_npc(i_npc), .i_stall(i_stall),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_F_pc(o_F_pc), .o_F_instr(o_F_instr), .o_F_valid(o_F_valid),
    .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, exp_req_cyc = -100, resp_cyc = -100, k_cur = 1;
  bit rand_k = 0, hold_exp = 0, exp_mis = 0;
  logic [31:0] exp_pc = RST_PC;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {a[15:0] ^ 16'h5a5a, ~a[31:16]} + 32'h1357_9bdf;
  endfunction

  function automatic logic [31:0] rand_npc();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 9) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  // One cycle: check outputs against the model, drive this cycle's inputs, step.
  task automatic tick(input bit stall, input logic [31:0] npc, input bit spur);
    bit req_e, in_wait;
    if (cyc == resp_cyc + 1) hold_exp = 1;
    req_e = (cyc == exp_req_cyc);
    chk("req", o_imem_req, req_e);
    chk("addr", o_imem_addr, exp_pc);
    chk("F_pc", o_F_pc, exp_pc);
    if (req_e) begin
      if (rand_k) k_cur = $urandom_range(1, 4);
      resp_cyc = cyc + k_cur;
    end
    chk("valid", o_F_valid, hold_exp);
    if (hold_exp) chk("F_instr", o_F_instr, mem_word(exp_pc));
    chk("misalign", o_misalign, exp_mis);
    in_wait = (cyc > exp_req_cyc) && (cyc <= resp_cyc);
    if (cyc == resp_cyc) begin
      i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(exp_pc);
    end else if (spur && !in_wait) begin
      i_imem_rvalid = 1'b1; i_imem_rdata = $urandom;
    end else begin
      i_imem_rvalid = 1'b0; i_imem_rdata = $urandom;
    end
    i_stall = stall;
    i_npc   = npc;
    if (hold_exp && !stall) begin
      exp_pc      = {npc[31:2], 2'b00};
      exp_mis     = exp_mis | (npc[1:0] != 2'b00);
      exp_req_cyc = cyc + 1;
      hold_exp    = 0;
    end
    @(posedge i_clk); #1;
    cyc++;
  endtask

  task automatic release_reset();
    chk("rst_req", o_imem_req, 0);
    chk("rst_valid", o_F_valid, 0);
    chk("rst_pc", o_F_pc, RST_PC);
    chk("rst_addr", o_imem_addr, RST_PC);
    chk("rst_instr", o_F_instr, 0);
    chk("rst_mis", o_misalign, 0);
    i_rst_n = 1'b1;
    exp_pc = RST_PC; exp_mis = 0; hold_exp = 0;
    resp_cyc = -100; exp_req_cyc = cyc + 1;
  endtask

  task automatic run_to_hold(input bit spur);
    for (int i = 0; i < 100 && !(hold_exp || cyc == resp_cyc + 1); i++)
      tick(1'b0, $urandom, spur);
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    release_reset();

    // Reset release, k=1, first instruction and sequential next PC.
    k_cur = 1;
    tick(0, $urandom, 0);
    tick(0, $urandom, 0);
    tick(0, $urandom, 0);
    chk("first_instr", o_F_instr, 32'h2408_0001);
    tick(0, 32'h3004, 0);

    // Stall for 4 cycles, then redirect to a branch target.
    run_to_hold(0);
    repeat (4) tick(1, $urandom, 0);
    chk("stall_pc", o_F_pc, 32'h3004);
    tick(0, 32'h3040, 0);

    // k=3 with spurious responses outside the wait window, then misaligned target.
    k_cur = 3;
    run_to_hold(1);
    chk("redir_pc", o_F_pc, 32'h3040);
    repeat (2) tick(1, $urandom, 1);
    tick(0, 32'h3006, 1);

    k_cur = 1;
    run_to_hold(0);
    chk("mis_pc", o_F_pc, 32'h3004);
    chk("mis_set", o_misalign, 1);
    for (int j = 0; j < 3; j++) begin
      tick(0, exp_pc + 32'd4, 0);
      run_to_hold(0);
    end
    chk("mis_sticky", o_misalign, 1);

    // Randomized traffic.
    rand_k = 1;
    repeat (1500) tick($urandom_range(0, 9) < 3, rand_npc(), $urandom_range(0, 3) == 0);

    // Asynchronous reset in the middle of a long wait.
    rand_k = 0; k_cur = 6;
    for (int i = 0; i < 200 && cyc != exp_req_cyc; i++)
      tick($urandom_range(0, 9) < 3, rand_npc(), 0);
    tick(0, $urandom, 0);
    i_imem_rvalid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_req", o_imem_req, 0);
    chk("arst_valid", o_F_valid, 0);
    chk("arst_pc", o_F_pc, RST_PC);
    @(posedge i_clk); #1;
    cyc++;
    release_reset();
    k_cur = 2;
    tick(0, $urandom, 0);
    tick(0, $urandom, 0);
    rand_k = 1;
    repeat (40) tick($urandom_range(0, 9) < 3, rand_npc(), $urandom_range(0, 3) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
